// File: rtl/fpga_cfg_loader.sv
// ============================================================================
//  Module   : fpga_cfg_loader
//  Purpose  : Streams configuration words LSB-first into per-column CLB config
//             chains, one column at a time, then pulses a commit strobe.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpga_cfg_loader #(
  parameter int NUM_COLS  = 2,
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [NUM_COLS-1:0] shift_enable,
  output logic [NUM_COLS-1:0] shift_in_hard,
  output logic [NUM_COLS-1:0] set_hard,
  output logic                busy,
  output logic                done
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int NW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_NEXT   = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_col, w_col_nxt;
  logic [BW-1:0]       r_bit_cnt, w_bit_nxt;
  logic [NW-1:0]       r_n, w_n_nxt, w_n_word;
  logic [WORD_W-1:0]   r_shreg, w_shreg_nxt;
  logic [31:0]         w_rem;
  logic [NUM_COLS-1:0] w_col_oh;
  logic                w_busy;

  logic                r_cfg_ready, r_busy, r_done;
  logic [NUM_COLS-1:0] r_shift_en, r_shift_in, r_set_hard;

  // Bits shifted from the current word: a full word, or whatever is left of the chain.
  assign w_rem    = 32'(CHAIN_LEN) - 32'(r_bit_cnt);
  assign w_n_word = (w_rem < 32'(WORD_W)) ? NW'(w_rem) : NW'(WORD_W);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_bit_nxt   = r_bit_cnt;
    w_n_nxt     = r_n;
    w_shreg_nxt = r_shreg;
    w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    if (abort && w_busy) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_LOAD;
            w_col_nxt   = '0;
            w_bit_nxt   = '0;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            w_shreg_nxt = cfg_data;
            w_n_nxt     = w_n_word;
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          w_shreg_nxt = r_shreg >> 1;
          w_bit_nxt   = r_bit_cnt + BW'(1);
          w_n_nxt     = r_n - NW'(1);
          if (r_n == NW'(1)) begin
            w_state_nxt = (w_bit_nxt == BW'(CHAIN_LEN)) ? S_NEXT : S_LOAD;
          end
        end
        S_NEXT: begin
          if (r_col == CW'(NUM_COLS - 1)) begin
            w_state_nxt = S_COMMIT;
          end else begin
            w_col_nxt   = r_col + CW'(1);
            w_bit_nxt   = '0;
            w_state_nxt = S_LOAD;
          end
        end
        S_COMMIT: w_state_nxt = S_DONE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_col_oh = NUM_COLS'(1) << w_col_nxt;

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_bit_cnt   <= '0;
      r_n         <= '0;
      r_shreg     <= '0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_shift_en  <= '0;
      r_shift_in  <= '0;
      r_set_hard  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_n         <= w_n_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cfg_ready <= (w_state_nxt == S_LOAD);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done      <= (w_state_nxt == S_DONE);
      r_shift_en  <= (w_state_nxt == S_SHIFT) ? w_col_oh : '0;
      r_shift_in  <= ((w_state_nxt == S_SHIFT) && w_shreg_nxt[0]) ? w_col_oh : '0;
      r_set_hard  <= (w_state_nxt == S_COMMIT) ? '1 : '0;
    end
  end

  assign cfg_ready     = r_cfg_ready;
  assign shift_enable  = r_shift_en;
  assign shift_in_hard = r_shift_in;
  assign set_hard      = r_set_hard;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fpga_cfg_loader.sv
// ============================================================================
//  Module   : tb_fpga_cfg_loader
//  Purpose  : Self-checking bench for fpga_cfg_loader against a bit-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpga_cfg_loader;

  localparam int NC   = 2;
  localparam int CL   = 10;
  localparam int WW   = 4;
  localparam int WPC  = (CL + WW - 1) / WW;
  localparam int CLB  = 8;
  localparam int WPCB = (CLB + WW - 1) / WW;

  logic          cclk = 1'b0;
  logic          rst;
  logic          start, abort, cfg_valid, cfg_ready, busy, done;
  logic [WW-1:0] cfg_data;
  logic [NC-1:0] shift_enable, shift_in_hard, set_hard;

  logic          b_start, b_valid, b_ready, b_busy, b_done;
  logic [WW-1:0] b_data;
  logic [NC-1:0] b_en, b_in, b_set;

  fpga_cfg_loader #(.NUM_COLS(NC), .CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .cclk(cclk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .shift_enable(shift_enable), .shift_in_hard(shift_in_hard),
    .set_hard(set_hard), .busy(busy), .done(done)
  );

  fpga_cfg_loader #(.NUM_COLS(NC), .CHAIN_LEN(CLB), .WORD_W(WW)) dut_b (
    .cclk(cclk), .rst(rst), .start(b_start), .abort(1'b0),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .shift_enable(b_en), .shift_in_hard(b_in),
    .set_hard(b_set), .busy(b_busy), .done(b_done)
  );

  always #5 cclk = ~cclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: column c, chain position k is bit (k mod WW) of word (c*wpc + k/WW).
  function automatic logic [31:0] model_stream(input logic [31:0] w[$], input int c,
                                               input int wpc, input int chain);
    logic [31:0] v = '0;
    for (int k = 0; k < chain; k++) v[k] = w[c*wpc + k/WW][k%WW];
    return v;
  endfunction

  function automatic logic [31:0] q2v(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  bit          qa[2][$];
  bit          qb[2][$];
  int          busy_cycles, sh_pulses, b_switch;
  logic [NC-1:0] sh_val;
  logic [31:0] wq[$];
  logic [31:0] wb[$];

  always @(negedge cclk) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        if (shift_enable[c]) qa[c].push_back(shift_in_hard[c]);
        if (b_en[c]) qb[c].push_back(b_in[c]);
      end
      if (b_en[1] && b_switch < 0) b_switch = qb[0].size();
      if (busy) busy_cycles++;
      if (set_hard != '0) begin
        sh_pulses++;
        sh_val = set_hard;
      end
      chk("one_col_shifting", 32'($countones(shift_enable) > 1), 32'd0);
      chk("inactive_col_bit", 32'((shift_enable != '0) && ((shift_in_hard & ~shift_enable) != '0)), 32'd0);
      chk("ready_during_shift", 32'(cfg_ready && (shift_enable != '0)), 32'd0);
    end
  end

  task automatic clear_mon();
    for (int c = 0; c < NC; c++) qa[c].delete();
    busy_cycles = 0;
    sh_pulses   = 0;
    sh_val      = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input bit toggle);
    int  idx = first;
    int  cyc = 0;
    bit  taken;
    while (idx < last && cyc < 400) begin
      cfg_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      cfg_data  = wq[idx][WW-1:0];
      @(negedge cclk);
      taken = cfg_valid && cfg_ready;
      @(posedge cclk); #1;
      if (taken) idx++;
      cyc++;
    end
    cfg_valid = 1'b0;
    chk("words_accepted", 32'(idx), 32'(last));
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge cclk); #1;
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(32'($urandom_range(0, (1 << WW) - 1)));
  endtask

  task automatic check_streams(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk({tag, "_len"}, 32'(qa[c].size()), 32'(CL));
      chk({tag, "_bits"}, q2v(qa[c]), model_stream(wq, c, WPC, CL));
    end
    chk({tag, "_commit_cnt"}, 32'(sh_pulses), 32'd1);
    chk({tag, "_commit_val"}, 32'(sh_val), 32'({NC{1'b1}}));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, cyc;
    bit  taken;
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_switch = -1;
    clear_mon();
    #12;
    chk("reset_outputs", 32'({cfg_ready, shift_enable, shift_in_hard, set_hard, busy, done}), 32'd0);
    @(posedge cclk); #1;
    rst = 1'b1;
    @(posedge cclk); #1;
    chk("idle_ready", 32'(cfg_ready), 32'd0);

    // Known-answer full load with valid held high.
    wq = '{32'h5, 32'hA, 32'h3, 32'hF, 32'h0, 32'h1};
    clear_mon();
    pulse_start();
    feed(0, 2*WPC, 1'b0);
    wait_done();
    check_streams("kat");
    chk("kat_col0", q2v(qa[0]), 32'h3A5);
    chk("kat_col1", q2v(qa[1]), 32'h10F);
    chk("kat_busy_cycles", 32'(busy_cycles), 32'(NC*(WPC + CL + 1) + 1));

    // Asynchronous reset while shifting.
    rand_words(2*WPC);
    clear_mon();
    pulse_start();
    feed(0, 1, 1'b0);
    chk("pre_reset_shifting", 32'(shift_enable), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'({cfg_ready, shift_enable, shift_in_hard, set_hard, busy, done}), 32'd0);
    @(posedge cclk); #1;
    rst = 1'b1;
    @(posedge cclk); #1;
    chk("post_reset_ready", 32'(cfg_ready), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Back-pressure with random words.
    for (int r = 0; r < 3; r++) begin
      rand_words(2*WPC);
      clear_mon();
      pulse_start();
      feed(0, 2*WPC, 1'b1);
      wait_done();
      check_streams("bp");
    end

    // start in DONE restarts; start while busy is ignored.
    rand_words(2*WPC);
    clear_mon();
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_ready", 32'(cfg_ready), 32'd1);
    feed(0, 2, 1'b0);
    pulse_start();
    feed(2, 2*WPC, 1'b0);
    wait_done();
    check_streams("busy_start");

    // Abort while col1's second word is shifting.
    rand_words(2*WPC);
    clear_mon();
    pulse_start();
    feed(0, WPC + 2, 1'b0);
    chk("abort_pre_col1", 32'(shift_enable), 32'd2);
    abort = 1'b1;
    @(posedge cclk); #1;
    abort = 1'b0;
    chk("abort_outs", 32'({cfg_ready, shift_enable, set_hard, busy, done}), 32'd0);
    repeat (20) @(posedge cclk);
    #1;
    chk("abort_no_commit", 32'(sh_pulses), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rand_words(2*WPC);
    clear_mon();
    pulse_start();
    feed(0, 2*WPC, 1'b0);
    wait_done();
    check_streams("after_abort");

    // Exact-fit chain on the second instance.
    for (int c = 0; c < NC; c++) qb[c].delete();
    wb.delete();
    for (int i = 0; i < NC*WPCB; i++) wb.push_back(32'($urandom_range(0, (1 << WW) - 1)));
    b_start = 1'b1;
    @(posedge cclk); #1;
    b_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < NC*WPCB && cyc < 400) begin
      b_valid = 1'b1;
      b_data  = wb[idx][WW-1:0];
      @(negedge cclk);
      taken = b_valid && b_ready;
      @(posedge cclk); #1;
      if (taken) idx++;
      cyc++;
    end
    b_valid = 1'b0;
    chk("fit_words", 32'(idx), 32'(NC*WPCB));
    cyc = 0;
    while (!b_done && cyc < 200) begin
      @(posedge cclk); #1;
      cyc++;
    end
    chk("fit_done", 32'(b_done), 32'd1);
    chk("fit_switch_at", 32'(b_switch), 32'(CLB));
    for (int c = 0; c < NC; c++) begin
      chk("fit_len", 32'(qb[c].size()), 32'(CLB));
      chk("fit_bits", q2v(qb[c]), model_stream(wb, c, WPCB, CLB));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
